// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS control unit (master) and the
// datapath/memory side (slave): instruction fields, memory handshake and controls.
interface mc_control_fsm_if #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 mem_ready;
  logic                 mem_to_reg;
  logic                 reg_dest;
  logic                 i_or_d;
  logic                 alu_src_a;
  logic                 ir_write;
  logic                 mem_write;
  logic                 pc_write;
  logic                 branch;
  logic                 branch_ne;
  logic                 reg_write;
  logic [1:0]           alu_src_b;
  logic [1:0]           pc_src;
  logic [ALUCTRL_W-1:0] alu_control;
  logic                 illegal_op;
  logic [CNT_W-1:0]     instr_retired;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
           pc_write, branch, branch_ne, reg_write, alu_src_b, pc_src,
           alu_control, illegal_op, instr_retired
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
           pc_write, branch, branch_ne, reg_write, alu_src_b, pc_src,
           alu_control, illegal_op, instr_retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: main FSM with folded ALU decoder, wait-state
// memory handshake, illegal-instruction trap and retired-instruction counter.
module mc_control_fsm #(
  parameter int         ALUCTRL_W = 3,
  parameter int         CNT_W     = 32,
  parameter logic [1:0] EXC_PCSRC = 2'b11
) (
  input logic               clk,
  input logic               reset,
  mc_control_fsm_if.master  bus
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, IEXEC, IWB, JUMP, EXC
  } state_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dest;
    logic       i_or_d;
    logic       alu_src_a;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       reg_write;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Moore controls of a state; only non-default values are set.
  function automatic ctrl_t moore_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c     = '0;
    c.alu = ALU_ADD;
    case (s)
      FETCH:  c.alu_src_b = 2'b01;
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  c.i_or_d = 1'b1;
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
      EXEC:   c.alu_src_a = 1'b1;
      ALUWB:  begin c.reg_write = 1'b1; c.reg_dest = 1'b1; end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu       = ALU_SUB;
        c.pc_src    = 2'b01;
        c.branch    = (op == OP_BEQ);
        c.branch_ne = (op == OP_BNE);
      end
      IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      IWB:    c.reg_write = 1'b1;
      JUMP:   begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      EXC:    begin c.illegal_op = 1'b1; c.pc_write = 1'b1; c.pc_src = EXC_PCSRC; end
      default: c.alu = ALU_ADD;
    endcase
    return c;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  ctrl_t            ctrl_r;
  logic             retire_s;
  logic [CNT_W-1:0] count_r;
  logic [2:0]       alu_s;
  logic             fetch_go_s;

  // Next-state decode and retirement detection.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      FETCH:  if (bus.mem_ready) next_state_s = DECODE; else next_state_s = FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:               next_state_s = MEMADR;
          OP_RTYPE:                   if (funct_ok(bus.funct)) next_state_s = EXEC;
                                      else next_state_s = EXC;
          OP_BEQ, OP_BNE:             next_state_s = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   next_state_s = IEXEC;
          OP_J:                       next_state_s = JUMP;
          default:                    next_state_s = EXC;
        endcase
      end
      MEMADR: if (bus.opcode == OP_SW) next_state_s = MEMWR; else next_state_s = MEMRD;
      MEMRD:  if (bus.mem_ready) next_state_s = MEMWB; else next_state_s = MEMRD;
      MEMWR:  begin
        if (bus.mem_ready) begin
          next_state_s = FETCH;
          retire_s     = 1'b1;
        end else begin
          next_state_s = MEMWR;
        end
      end
      EXEC:   next_state_s = ALUWB;
      IEXEC:  next_state_s = IWB;
      MEMWB, ALUWB, BRANCH, IWB, JUMP: begin
        next_state_s = FETCH;
        retire_s     = 1'b1;
      end
      EXC:    next_state_s = FETCH;
      default: next_state_s = FETCH;
    endcase
  end

  // State, lookahead-registered Moore controls and retired counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
      ctrl_r  <= moore_ctrl(FETCH, 6'b000000);
      count_r <= '0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= moore_ctrl(next_state_s, bus.opcode);
      if (retire_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Fetch writes wait on the handshake; EXEC/IEXEC decode the live IR fields.
  always_comb begin
    fetch_go_s = (state_r == FETCH) && bus.mem_ready;
    if (state_r == EXEC) begin
      alu_s = funct_alu(bus.funct);
    end else if (state_r == IEXEC) begin
      alu_s = imm_alu(bus.opcode);
    end else begin
      alu_s = ctrl_r.alu;
    end
    bus.alu_control      = '0;
    bus.alu_control[2:0] = alu_s;
  end

  assign bus.mem_to_reg    = ctrl_r.mem_to_reg;
  assign bus.reg_dest      = ctrl_r.reg_dest;
  assign bus.i_or_d        = ctrl_r.i_or_d;
  assign bus.alu_src_a     = ctrl_r.alu_src_a;
  assign bus.ir_write      = fetch_go_s;
  assign bus.mem_write     = ctrl_r.mem_write;
  assign bus.pc_write      = ctrl_r.pc_write | fetch_go_s;
  assign bus.branch        = ctrl_r.branch;
  assign bus.branch_ne     = ctrl_r.branch_ne;
  assign bus.reg_write     = ctrl_r.reg_write;
  assign bus.alu_src_b     = ctrl_r.alu_src_b;
  assign bus.pc_src        = ctrl_r.pc_src;
  assign bus.illegal_op    = ctrl_r.illegal_op;
  assign bus.instr_retired = count_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: two control units (default widths and ALUCTRL_W=5/CNT_W=4)
// driven identically, checked each cycle against an instruction-level model.
module tb_mc_control_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                 P_MEMWB = 4, P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7,
                 P_BRANCH = 8, P_IEXEC = 9, P_IWB = 10, P_JUMP = 11, P_EXC = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        mr;
  logic [31:0] retired;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if #(.ALUCTRL_W(3), .CNT_W(32)) bus_a ();
  mc_control_fsm_if #(.ALUCTRL_W(5), .CNT_W(4))  bus_b ();

  mc_control_fsm #(.ALUCTRL_W(3), .CNT_W(32), .EXC_PCSRC(2'b11)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mc_control_fsm #(.ALUCTRL_W(5), .CNT_W(4), .EXC_PCSRC(2'b11)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  assign bus_a.opcode = op;  assign bus_a.funct = fn;  assign bus_a.mem_ready = mr;
  assign bus_b.opcode = op;  assign bus_b.funct = fn;  assign bus_b.mem_ready = mr;

  wire [19:0] obs_a = {bus_a.mem_to_reg, bus_a.reg_dest, bus_a.i_or_d, bus_a.alu_src_a,
                       bus_a.ir_write, bus_a.mem_write, bus_a.pc_write, bus_a.branch,
                       bus_a.branch_ne, bus_a.reg_write, bus_a.illegal_op,
                       bus_a.alu_src_b, bus_a.pc_src, 2'b00, bus_a.alu_control};
  wire [19:0] obs_b = {bus_b.mem_to_reg, bus_b.reg_dest, bus_b.i_or_d, bus_b.alu_src_a,
                       bus_b.ir_write, bus_b.mem_write, bus_b.pc_write, bus_b.branch,
                       bus_b.branch_ne, bus_b.reg_write, bus_b.illegal_op,
                       bus_b.alu_src_b, bus_b.pc_src, bus_b.alu_control};

  // Output table per phase of an instruction, straight from the control rules.
  function automatic logic [19:0] expect_outs(input int ph, input logic [5:0] o,
                                              input logic [5:0] f, input logic m);
    logic mtr, rd, iod, asa, irw, mw, pcw, br, bn, rw, ill;
    logic [1:0] asb, pcs;
    logic [4:0] alu;
    {mtr, rd, iod, asa, irw, mw, pcw, br, bn, rw, ill} = 11'b0;
    asb = 2'b00; pcs = 2'b00; alu = 5'b00010;
    case (ph)
      P_FETCH:  begin asb = 2'b01; irw = m; pcw = m; end
      P_DECODE: asb = 2'b11;
      P_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      P_MEMRD:  iod = 1'b1;
      P_MEMWB:  begin rw = 1'b1; mtr = 1'b1; end
      P_MEMWR:  begin iod = 1'b1; mw = 1'b1; end
      P_EXEC: begin
        asa = 1'b1;
        case (f)
          6'b100010: alu = 5'b00110;
          6'b100100: alu = 5'b00000;
          6'b100101: alu = 5'b00001;
          6'b101010: alu = 5'b00111;
          default:   alu = 5'b00010;
        endcase
      end
      P_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
      P_BRANCH: begin asa = 1'b1; alu = 5'b00110; pcs = 2'b01; br = (o == BEQ); bn = (o == BNE); end
      P_IEXEC: begin
        asa = 1'b1; asb = 2'b10;
        alu = (o == ANDI) ? 5'b00000 : (o == ORI) ? 5'b00001 : 5'b00010;
      end
      P_IWB:    rw = 1'b1;
      P_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
      P_EXC:    begin ill = 1'b1; pcw = 1'b1; pcs = 2'b11; end
      default:  alu = 5'b00010;
    endcase
    return {mtr, rd, iod, asa, irw, mw, pcw, br, bn, rw, ill, asb, pcs, alu};
  endfunction

  task automatic check_now(input int ph);
    logic [19:0] exp;
    exp = expect_outs(ph, op, fn, mr);
    checks++;
    assert (obs_a === exp) else begin
      errors++;
      $error("FAIL outs_a ph=%0d op=%b fn=%b got=%b want=%b", ph, op, fn, obs_a, exp);
    end
    checks++;
    assert (obs_b === exp) else begin
      errors++;
      $error("FAIL outs_b ph=%0d op=%b fn=%b got=%b want=%b", ph, op, fn, obs_b, exp);
    end
    checks++;
    assert (bus_a.instr_retired === retired) else begin
      errors++;
      $error("FAIL cnt_a got=%0d want=%0d", bus_a.instr_retired, retired);
    end
    checks++;
    assert (bus_b.instr_retired === retired[3:0]) else begin
      errors++;
      $error("FAIL cnt_b got=%0d want=%0d", bus_b.instr_retired, retired[3:0]);
    end
  endtask

  // One clock cycle in a given phase: drive handshake, check mid-cycle, advance.
  task automatic step(input int ph, input logic m);
    mr = m;
    @(negedge clk);
    check_now(ph);
    @(posedge clk);
    #1;
  endtask

  // Whole instruction: phase list from the opcode class, waits in memory phases.
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f,
                          input int wf, input int wm);
    int  ph[$];
    logic legal_rt;
    op = o; fn = f;
    legal_rt = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    if (o == LW)                               ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB};
    else if (o == SW)                          ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWR};
    else if (o == RT && legal_rt)              ph = '{P_FETCH, P_DECODE, P_EXEC, P_ALUWB};
    else if (o == BEQ || o == BNE)             ph = '{P_FETCH, P_DECODE, P_BRANCH};
    else if (o == ADDI || o == ANDI || o == ORI) ph = '{P_FETCH, P_DECODE, P_IEXEC, P_IWB};
    else if (o == JMP)                         ph = '{P_FETCH, P_DECODE, P_JUMP};
    else                                       ph = '{P_FETCH, P_DECODE, P_EXC};
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH) begin
        repeat (wf) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
      end else if (ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
        repeat (wm) step(ph[i], 1'b0);
        step(ph[i], 1'b1);
      end else begin
        step(ph[i], 1'($urandom_range(0, 1)));
      end
    end
    if (ph[ph.size()-1] != P_EXC) retired = retired + 32'd1;
  endtask

  initial begin
    logic [5:0] table_op [9];
    logic [5:0] table_fn [5];
    logic [5:0] ro, rf;
    table_op = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP};
    table_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1; op = 6'b000000; fn = 6'b000000; mr = 1'b0; retired = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check_now(P_FETCH);
    @(posedge clk); #1;
    reset = 1'b0;

    do_instr(LW, 6'b000000, 0, 0);
    do_instr(ADDI, 6'b000000, 0, 0);
    do_instr(SW, 6'b000000, 1, 3);
    do_instr(RT, 6'b101010, 0, 0);
    do_instr(RT, 6'b100010, 2, 0);
    do_instr(BNE, 6'b000000, 0, 0);
    do_instr(BEQ, 6'b000000, 0, 0);
    do_instr(6'b111111, 6'b000000, 0, 0);
    do_instr(RT, 6'b000111, 0, 0);
    do_instr(ANDI, 6'b000000, 0, 0);
    do_instr(ORI, 6'b000000, 0, 0);
    do_instr(LW, 6'b000000, 1, 2);

    // Reset asserted away from any clock edge while MEMRD is waiting.
    op = LW; fn = 6'b000000;
    step(P_FETCH, 1'b1);
    step(P_DECODE, 1'b1);
    step(P_MEMADR, 1'b0);
    step(P_MEMRD, 1'b0);
    #2;
    reset = 1'b1;
    retired = 32'd0;
    #1;
    check_now(P_FETCH);
    @(posedge clk); #1;
    reset = 1'b0;
    do_instr(LW, 6'b000000, 2, 1);

    repeat (16) do_instr(JMP, 6'b000000, 0, 0);

    for (int k = 0; k < 40; k++) begin
      ro = table_op[$urandom_range(0, 8)];
      rf = table_fn[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) ro = 6'($urandom);
      if ($urandom_range(0, 5) == 0) rf = 6'($urandom);
      do_instr(ro, rf, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    mr = 1'b0;
    @(negedge clk);
    check_now(P_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised next-generation multicycle MIPS control unit: main FSM with the ALU decoder folded in.
- Adds BNE, ANDI, ORI, wait-state memory handshake (mem_ready), illegal-instruction trap and a retired-instruction counter.
- Every output is driven to a defined value in every state; no X.
- Sits between the instruction register (opcode/funct) and the multicycle datapath muxes, register file and memory.

Parameters:
- ALUCTRL_W, 3, width of alu_control; must be >=3; codes zero-extended above bit 2.
- CNT_W, 32, width of the instr_retired counter.
- EXC_PCSRC, 2'b11, pc_src value that selects the exception vector.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- mem_ready  in  1  memory completes the current access this cycle.
- mem_to_reg, reg_dest, i_or_d, alu_src_a  out  1 each  datapath mux selects.
- ir_write, mem_write, pc_write, branch, branch_ne, reg_write  out  1 each  enables.
- alu_src_b  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- pc_src  out  2  PC select: 00 ALU, 01 ALUOut, 10 jump target, EXC_PCSRC vector.
- alu_control  out  ALUCTRL_W  ALU operation.
- illegal_op  out  1  one-cycle trap pulse.
- instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, any state, mid-access included): state=FETCH, instr_retired=0. Outputs are Moore and take FETCH values immediately.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, J 000010.
- Supported R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- ALU codes: ADD 010, SUB 110, AND 000, OR 001, SLT 111.
- Default for every output in every state is 0 (alu_control = ADD); each state asserts only the values listed below.
- FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - ir_write and pc_write asserted only when mem_ready=1, then go to DECODE.
  - Otherwise stay in FETCH with no write.
- DECODE: alu_src_a=0, alu_src_b=11, ADD. Next state:
  - LW/SW -> MEMADR.
  - RTYPE with supported funct -> EXEC.
  - BEQ/BNE -> BRANCH.
  - ADDI/ANDI/ORI -> IEXEC.
  - J -> JUMP.
  - Any other opcode, or RTYPE with unsupported funct -> EXC.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. LW -> MEMRD, SW -> MEMWR.
- MEMRD: i_or_d=1. Hold until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dest=0 -> FETCH.
- MEMWR: i_or_d=1, mem_write=1, held for every cycle in the state. Exit to FETCH on the cycle mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct -> ALUWB.
- ALUWB: reg_write=1, reg_dest=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. branch=1 for BEQ, branch_ne=1 for BNE (never both) -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. ADDI=ADD, ANDI=AND, ORI=OR; opcode is sampled every cycle, no latching -> IWB.
- IWB: reg_write=1, reg_dest=0, mem_to_reg=0 -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- EXC: illegal_op=1, pc_write=1, pc_src=EXC_PCSRC, for exactly one cycle -> FETCH. No register or memory write.
- instr_retired increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, IWB, JUMP, and leaving MEMWR with mem_ready=1.
  - EXC does not count.
  - Wraps from all-ones to 0.
- Cycle counts with mem_ready tied to 1: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3, illegal 3. Each added wait cycle in FETCH, MEMRD or MEMWR adds one cycle.

Test Plan:
- mem_ready=1, LW then ADDI -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB then 4-state ADDI sequence; instr_retired=2 after 9 cycles; reg_write high exactly in MEMWB and IWB.
- SW with mem_ready low for 3 cycles in MEMWR -> mem_write high 4 consecutive cycles, i_or_d=1 throughout; counter increments once, on the exit edge.
- R-type funct 101010 -> alu_control=111 in EXEC, reg_dest=1 in ALUWB. BNE -> branch_ne=1, branch=0, alu_control=110, pc_src=01.
- Opcode 111111, then RTYPE funct 000111 -> each gives illegal_op one-cycle pulse, pc_src=11, pc_write=1, reg_write=0; instr_retired unchanged.
- Assert reset mid-MEMRD wait -> FETCH outputs immediately (asynchronous), counter=0. After release, normal fetch resumes on the first mem_ready.
- CNT_W=4, 16 J instructions -> counter wraps 15 -> 0. ALUCTRL_W=5, ORI -> alu_control=00001.
